// File: rtl/vga_capture_if.sv
// Wishbone write-master bundle between the VGA capture block and the SDRAM controller.
interface vga_capture_if;
    logic [31:0] adr;
    logic [15:0] dat_ms;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (output adr, dat_ms, cyc, stb, we, sel, cti, bte, input ack);
    modport slave  (input adr, dat_ms, cyc, stb, we, sel, cti, bte, output ack);
endinterface

// File: rtl/vga_capture.sv
// VGA stream capture: rebuilds pixel coordinates from sync/blank, packs RGB565 and
// writes each active pixel into the framebuffer through a small FIFO and a Wishbone master.
module vga_capture #(
    parameter int          vga_HDISP = 640,
    parameter int          vga_VDISP = 480,
    parameter int          FIFO_AW   = 4,
    parameter logic [31:0] FB_BASE   = 32'h0
) (
    input  logic          vga_CLK,
    input  logic          rst,
    input  logic          vid_hs,
    input  logic          vid_vs,
    input  logic          vid_blank,
    input  logic [7:0]    vid_r,
    input  logic [7:0]    vid_g,
    input  logic [7:0]    vid_b,
    vga_capture_if.master wshb,
    output logic          locked,
    output logic          overflow,
    output logic [7:0]    frame_cnt
);
    localparam int NPIX  = vga_HDISP * vga_VDISP;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int X_W   = $clog2(vga_HDISP + 1);
    localparam int Y_W   = $clog2(vga_VDISP + 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int ENT_W = IDX_W + 16;

    localparam logic [1:0] S_WAIT_VS  = 2'd0;
    localparam logic [1:0] S_WAIT_ACT = 2'd1;
    localparam logic [1:0] S_CAP      = 2'd2;

    localparam logic [FIFO_AW+1:0] DEPTH_V = (FIFO_AW + 2)'(DEPTH);

    // Input stage
    logic       hs_reg, vs_reg, vs_prev_reg, blank_reg;
    logic [7:0] r_reg, g_reg, b_reg;
    logic       vs_fall;
    logic       unused_bits;

    always_ff @(posedge vga_CLK) begin
        if (rst) begin
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
            vs_prev_reg <= 1'b1;
            blank_reg   <= 1'b0;
            r_reg       <= '0;
            g_reg       <= '0;
            b_reg       <= '0;
        end else begin
            hs_reg      <= vid_hs;
            vs_reg      <= vid_vs;
            vs_prev_reg <= vs_reg;
            blank_reg   <= vid_blank;
            r_reg       <= vid_r;
            g_reg       <= vid_g;
            b_reg       <= vid_b;
        end
    end

    assign vs_fall     = vs_prev_reg & ~vs_reg;
    // Coordinates come from VS/BLANK alone; HS and the truncated colour LSBs are not needed.
    assign unused_bits = ^{hs_reg, r_reg[2:0], g_reg[1:0], b_reg[2:0]};

    // Frame tracking state machine
    logic [1:0]       state_reg, state_next;
    logic [X_W-1:0]   x_reg, x_next;
    logic [Y_W-1:0]   y_reg, y_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             locked_reg, locked_next;
    logic [7:0]       frame_cnt_reg, frame_next;
    logic             advance;

    always_comb begin
        state_next  = state_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        idx_next    = idx_reg;
        locked_next = locked_reg;
        frame_next  = frame_cnt_reg;
        advance     = 1'b0;
        case (state_reg)
            S_WAIT_VS: begin
                x_next   = '0;
                y_next   = '0;
                idx_next = '0;
                if (vs_fall) state_next = S_WAIT_ACT;
            end
            S_WAIT_ACT: begin
                x_next   = '0;
                y_next   = '0;
                idx_next = '0;
                if (!vs_fall && vs_reg && blank_reg) begin
                    locked_next = 1'b1;
                    advance     = 1'b1;
                end
            end
            S_CAP: begin
                if (vs_fall) begin
                    // A VS edge mid-frame doubles as the start trigger of the next frame.
                    locked_next = 1'b0;
                    state_next  = S_WAIT_ACT;
                    x_next      = '0;
                    y_next      = '0;
                    idx_next    = '0;
                end else if ((blank_reg && y_reg == Y_W'(vga_VDISP)) ||
                             (!blank_reg && x_reg != '0)) begin
                    locked_next = 1'b0;
                    state_next  = S_WAIT_VS;
                end else if (blank_reg) begin
                    advance = 1'b1;
                end
            end
            default: state_next = S_WAIT_VS;
        endcase

        // x/y/idx are zero whenever we are outside CAP, so this path also serves pixel (0,0).
        if (advance) begin
            state_next = S_CAP;
            idx_next   = idx_reg + IDX_W'(1);
            if (x_reg == X_W'(vga_HDISP - 1)) begin
                x_next = '0;
                if (y_reg == Y_W'(vga_VDISP - 1)) begin
                    y_next     = '0;
                    idx_next   = '0;
                    frame_next = frame_cnt_reg + 8'd1;
                    state_next = S_WAIT_VS;
                end else begin
                    y_next = y_reg + Y_W'(1);
                end
            end else begin
                x_next = x_reg + X_W'(1);
            end
        end
    end

    always_ff @(posedge vga_CLK) begin
        if (rst) begin
            state_reg     <= S_WAIT_VS;
            x_reg         <= '0;
            y_reg         <= '0;
            idx_reg       <= '0;
            locked_reg    <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            idx_reg       <= idx_next;
            locked_reg    <= locked_next;
            frame_cnt_reg <= frame_next;
        end
    end

    // FIFO: array storage plus the Wishbone output register, which counts as one entry
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   mem_cnt;
    logic [FIFO_AW+1:0] total_cnt;
    logic               full, mem_empty, push_en, pop, load;
    logic               stb_reg, overflow_reg;
    logic [31:0]        adr_reg;
    logic [15:0]        dat_reg;
    logic [ENT_W-1:0]   head_ent;
    logic [31:0]        head_adr;

    assign mem_cnt   = wr_ptr_reg - rd_ptr_reg;
    assign total_cnt = {1'b0, mem_cnt} + {{(FIFO_AW + 1){1'b0}}, stb_reg};
    assign full      = (total_cnt >= DEPTH_V);
    assign mem_empty = (wr_ptr_reg == rd_ptr_reg);
    assign push_en   = advance & ~full;
    assign pop       = stb_reg & wshb.ack;
    assign load      = ~mem_empty & (~stb_reg | wshb.ack);
    assign head_ent  = mem[rd_ptr_reg[FIFO_AW-1:0]];
    assign head_adr  = FB_BASE + (32'(head_ent[ENT_W-1:16]) << 1);

    always_ff @(posedge vga_CLK) begin
        if (push_en)
            mem[wr_ptr_reg[FIFO_AW-1:0]] <= {idx_reg, b_reg[7:3], g_reg[7:2], r_reg[7:3]};
    end

    always_ff @(posedge vga_CLK) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            stb_reg      <= 1'b0;
            adr_reg      <= FB_BASE;
            dat_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_en)
                wr_ptr_reg <= wr_ptr_reg + (FIFO_AW + 1)'(1);
            if (advance && full)
                overflow_reg <= 1'b1;
            if (load) begin
                stb_reg    <= 1'b1;
                adr_reg    <= head_adr;
                dat_reg    <= head_ent[15:0];
                rd_ptr_reg <= rd_ptr_reg + (FIFO_AW + 1)'(1);
            end else if (pop) begin
                stb_reg <= 1'b0;
            end
        end
    end

    assign wshb.cyc    = stb_reg;
    assign wshb.stb    = stb_reg;
    assign wshb.we     = 1'b1;
    assign wshb.sel    = 2'b11;
    assign wshb.cti    = 3'b000;
    assign wshb.bte    = 2'b00;
    assign wshb.adr    = adr_reg;
    assign wshb.dat_ms = dat_reg;

    assign locked    = locked_reg;
    assign overflow  = overflow_reg;
    assign frame_cnt = frame_cnt_reg;
endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture: the video driver queues expected framebuffer writes,
// an independent bus monitor checks every strobed write against the queue head.
module tb_vga_capture;
    localparam int          H  = 8;
    localparam int          V  = 4;
    localparam int          AW = 4;
    localparam logic [31:0] FB = 32'h1000;

    logic       vga_CLK = 1'b0;
    logic       rst = 1'b1;
    logic       vid_hs = 1'b1, vid_vs = 1'b1, vid_blank = 1'b0;
    logic [7:0] vid_r = '0, vid_g = '0, vid_b = '0;
    logic       locked, overflow;
    logic [7:0] frame_cnt;

    vga_capture_if wb();

    vga_capture #(.vga_HDISP(H), .vga_VDISP(V), .FIFO_AW(AW), .FB_BASE(FB)) dut (
        .vga_CLK   (vga_CLK),
        .rst       (rst),
        .vid_hs    (vid_hs),
        .vid_vs    (vid_vs),
        .vid_blank (vid_blank),
        .vid_r     (vid_r),
        .vid_g     (vid_g),
        .vid_b     (vid_b),
        .wshb      (wb),
        .locked    (locked),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    always #5 vga_CLK = ~vga_CLK;

    int          n_checks = 0, n_fail = 0;
    int          cycle_cnt = 0;
    int          n_writes = 0, n_expected = 0;
    logic [47:0] sb[$];
    int          ack_mode = 1;
    bit          exp_on = 0;
    int          exp_idx = 0, exp_cap = 0, exp_pushed = 0;
    bit          lat_en = 0;
    int          lat_drive = -1, lat_stb = -1;

    function automatic logic [15:0] pack565(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {b[7:3], g[7:2], r[7:3]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge vga_CLK);
            #1;
        end
    endtask

    initial forever begin
        @(posedge vga_CLK);
        cycle_cnt++;
    end

    initial begin
        wb.ack = 1'b1;
        forever begin
            @(posedge vga_CLK);
            #1;
            case (ack_mode)
                0:       wb.ack = 1'b0;
                1:       wb.ack = 1'b1;
                default: wb.ack = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Bus monitor: every strobed cycle must present the oldest outstanding expected write.
    initial forever begin
        @(negedge vga_CLK);
        if (!rst && wb.stb) begin
            if (lat_stb < 0 && lat_drive >= 0) lat_stb = cycle_cnt;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: adr 0x%0h dat 0x%0h while none required", wb.adr, wb.dat_ms);
            end else begin
                check("wb_adr", wb.adr, sb[0][47:16]);
                check("wb_dat", {16'h0, wb.dat_ms}, {16'h0, sb[0][15:0]});
                if (wb.ack) begin
                    void'(sb.pop_front());
                    n_writes++;
                    $display("write %0d adr=0x%0h dat=0x%04h", n_writes, wb.adr, wb.dat_ms);
                end
            end
        end
    end

    task automatic idle(input int n);
        vid_blank = 1'b0;
        tick(n);
    endtask

    task automatic vs_pulse();
        vid_blank = 1'b0;
        vid_vs = 1'b0;
        tick(3);
        vid_vs = 1'b1;
        tick(3);
        exp_idx = 0;
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic [15:0] edat);
        vid_r = r;
        vid_g = g;
        vid_b = b;
        vid_blank = 1'b1;
        if (lat_en && lat_drive < 0) lat_drive = cycle_cnt;
        if (exp_on) begin
            if (exp_cap == 0 || exp_pushed < exp_cap) begin
                sb.push_back({FB + 32'(exp_idx * 2), edat});
                exp_pushed++;
                n_expected++;
            end
            exp_idx++;
        end
        tick(1);
    endtask

    // pat 0: random colours; pat 1: colour derived from the pixel index, (0,0) is the packing probe
    task automatic send_line(input int y, input int npix, input int pat);
        logic [7:0] r, g, b;
        for (int x = 0; x < npix; x++) begin
            if (pat == 1 && y == 0 && x == 0) begin
                send_pixel(8'hFF, 8'h00, 8'h80, 16'h801F);
            end else begin
                if (pat == 1) begin
                    r = 8'((y * H + x) << 3);
                    g = 8'((y * H + x) << 2);
                    b = 8'((y * H + x) << 3);
                end else begin
                    r = 8'($urandom);
                    g = 8'($urandom);
                    b = 8'($urandom);
                end
                send_pixel(r, g, b, pack565(r, g, b));
            end
        end
        vid_blank = 1'b0;
        vid_hs = 1'b0;
        tick(1);
        vid_hs = 1'b1;
        tick($urandom_range(4, 1));
    endtask

    task automatic send_frame(input int pat);
        vs_pulse();
        for (int y = 0; y < V; y++) send_line(y, H, pat);
        idle(4);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000 && (sb.size() != 0 || wb.stb); i++) tick(1);
        check(name, sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick(3);
        check("rst_locked", locked, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_cyc", wb.cyc, 0);
        check("rst_stb", wb.stb, 0);
        check("rst_adr", wb.adr, FB);
        check("rst_dat", wb.dat_ms, 0);
        check("const_we", wb.we, 1);
        check("const_sel", wb.sel, 3);
        check("const_cti", wb.cti, 0);
        check("const_bte", wb.bte, 0);
        rst = 1'b0;
        tick(2);

        // Two nominal frames with ack tied high, first one index-patterned with the packing probe
        ack_mode = 1;
        exp_on = 1;
        exp_cap = 0;
        lat_en = 1;
        send_frame(1);
        lat_en = 0;
        check("first_write_latency", lat_stb - lat_drive, 3);
        send_frame(0);
        wait_drain("drain_nominal");
        check("nominal_frame_cnt", frame_cnt, 2);
        check("nominal_overflow", overflow, 0);
        check("nominal_locked", locked, 1);
        check("nominal_writes", n_writes, 2 * H * V);

        // Random acknowledge pattern
        ack_mode = 2;
        send_frame(0);
        ack_mode = 1;
        wait_drain("drain_random_ack");
        check("rand_frame_cnt", frame_cnt, 3);
        check("rand_overflow", overflow, 0);

        // Stalled bus: only the first 2^AW pixels fit, the rest are dropped
        ack_mode = 0;
        tick(2);
        exp_cap = 1 << AW;
        exp_pushed = 0;
        send_frame(0);
        tick(5);
        check("stall_overflow", overflow, 1);
        check("stall_frame_cnt", frame_cnt, 4);
        ack_mode = 1;
        wait_drain("drain_stall");
        exp_cap = 0;
        tick(3);
        check("overflow_sticky", overflow, 1);

        // Short line: pixels before the error are written, then nothing until the next VS
        vs_pulse();
        send_line(0, H, 0);
        send_line(1, 6, 0);
        exp_on = 0;
        tick(2);
        check("short_line_locked", locked, 0);
        send_line(2, H, 0);
        send_line(3, H, 0);
        idle(4);
        wait_drain("drain_short_line");
        check("short_line_frame_cnt", frame_cnt, 4);
        exp_on = 1;
        send_frame(0);
        wait_drain("drain_recovery");
        check("recovery_frame_cnt", frame_cnt, 5);
        check("recovery_locked", locked, 1);

        // VS mid-frame: abort and restart from index 0
        vs_pulse();
        send_line(0, H, 0);
        send_line(1, H, 0);
        vs_pulse();
        check("midvs_locked", locked, 0);
        check("midvs_frame_cnt", frame_cnt, 5);
        for (int y = 0; y < V; y++) send_line(y, H, 0);
        idle(4);
        wait_drain("drain_midvs");
        check("midvs_restart_frame_cnt", frame_cnt, 6);
        check("midvs_restart_locked", locked, 1);

        // Reset while a write is pending
        ack_mode = 0;
        tick(2);
        vs_pulse();
        for (int i = 0; i < 3; i++) send_pixel(8'(i * 40), 8'(i * 20), 8'(i * 60), pack565(8'(i * 40), 8'(i * 20), 8'(i * 60)));
        idle(1);
        for (int i = 0; i < 20 && !wb.stb; i++) tick(1);
        check("stb_before_reset", wb.stb, 1);
        rst = 1'b1;
        tick(1);
        check("reset_stb", wb.stb, 0);
        check("reset_cyc", wb.cyc, 0);
        check("reset_locked", locked, 0);
        check("reset_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        n_expected -= sb.size();
        sb.delete();
        exp_on = 0;
        ack_mode = 1;
        tick(2);
        send_line(1, H, 0);
        send_line(2, H, 0);
        idle(4);
        check("post_reset_locked", locked, 0);
        check("post_reset_overflow", overflow, 0);
        exp_on = 1;
        send_frame(0);
        wait_drain("drain_after_reset");
        check("resume_frame_cnt", frame_cnt, 1);
        check("resume_locked", locked, 1);
        check("total_writes", n_writes, n_expected);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
